dm_access_ctrl: RTL and testbench
=================================

Name: dm_access_ctrl

Overview:
- Initiator side of the data-memory port. Accepts one load/store request at a time from the MEM stage, then drives the memory's byte-enable, write, address and write-data inputs.
- Returns formatted read data: lane extraction, sign/zero extension and optional byte reversal.
- Sits between the pipeline MEM stage and the DM array, which has synchronous byte-enabled write and combinational read.
- Misaligned accesses are split into two word accesses when the optional feature is compiled in.

Parameters:
- ADDR_W, 32, address width.
- DM_BASE, 32'h0000_3000, byte address of memory word 0.
- DM_BYTES, 4096, memory size in bytes (multiple of 4).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_wr  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal.
- req_rev  in  1  byte-reverse data (lhbr/lwbr/sthbr/stwbr).
- req_sext  in  1  sign-extend load (byte/half only).
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-justified.
- rsp_valid  out  1  one-cycle response pulse, no backpressure.
- rsp_rdata  out  32  formatted load data; 0 for stores and errors.
- rsp_err  out  1  range, size or alignment error; qualified by rsp_valid.
- dm_addr  out  ADDR_W  word-aligned byte address to the memory.
- dm_be  out  4  byte enables; bit k = byte lane k.
- dm_wr  out  1  write strobe.
- dm_din  out  32  write data to the memory.
- dm_dout  in  32  combinational read data from the memory.

Behaviour:
- Byte lane mapping: byte offset k (0..3) within a word is dm_dout/dm_din bits [8k+7:8k] and is enabled by dm_be[k].
- Reset (async, rst_n=0) forces:
  - state IDLE;
  - req_ready=0 while reset is asserted, 1 in IDLE;
  - rsp_valid=0, rsp_err=0, rsp_rdata=0;
  - dm_be=0, dm_wr=0, dm_addr=0, dm_din=0.
- States and transitions:
  - IDLE: req_ready=1. On accept, latch all req_* fields and go to CHK.
  - CHK: compute off = (addr-DM_BASE) mod 4 and span = off + bytes(size).
    - split = span > 4.
    - err if size==3, or addr < DM_BASE, or (addr-DM_BASE+bytes) > DM_BYTES.
    - err also if split and the feature is disabled.
    - err -> RESP; otherwise -> ACC0.
  - ACC0: drive the first word at dm_addr = addr & ~3, with dm_be = low 4 bits of (byte mask << off).
    - dm_wr=1 for one cycle on stores.
    - Loads capture dm_dout into the low word of a 64-bit window.
    - Next state: split -> ACC1, else RESP.
  - ACC1: drive dm_addr + 4 with dm_be = mask bits [7:4].
    - dm_wr=1 on stores.
    - Loads capture dm_dout into the high word.
    - Next state: RESP.
  - RESP: rsp_valid=1 for exactly one cycle with rsp_rdata/rsp_err valid, then IDLE.
- req_ready=0 in CHK, ACC0, ACC1 and RESP, so there is never more than one outstanding request.
- Latency from accept edge T:
  - rsp_valid at T+3 for an unsplit access;
  - T+4 for a split access;
  - T+2 for an error.
- dm_be=0 and dm_wr=0 in every state other than ACC0/ACC1. An error performs no memory access.
- Store data path:
  - wdata is byte-reversed within its size if rev;
  - then placed in a 64-bit window shifted left by 8*off;
  - dm_din is the window half matching the current access.
- Load data path:
  - window >> 8*off, truncated to the access size;
  - byte-reversed if rev;
  - then sign-extended if sext && !rev && size<2, otherwise zero-extended.
- rev on a byte access is a no-op.
- Range is checked on the whole span before any access, so a split store never half-commits because of a range error.
- Reset mid-operation: the state machine aborts immediately. A write already strobed in ACC0 stays committed; a pending ACC1 is dropped and no response is issued.

Optional Feature:
- DM_ACC_SPLIT_EN
  - Defined: misaligned half/word accesses that cross a word boundary are split into ACC0 and ACC1 as above.
  - Undefined: ACC1 does not exist. Any access with span > 4 returns rsp_err=1 with no memory access. Half at offset 1 (span 3) remains legal.

Test Plan:
- Aligned word store 0x1234_5678 at DM_BASE+8, then load word -> ACC0 has dm_be=4'hF and dm_wr=1; load returns 0x1234_5678, rsp_err=0, rsp_valid at T+3.
- Byte store 0xA5 at DM_BASE+0x0D over word 0, then signed byte load there -> dm_be=4'b0010, dm_din[15:8]=0xA5; load returns 0xFFFF_FFA5; unsigned load returns 0x0000_00A5.
- Halfword load with rev at offset 2 of word 0xAABB_CCDD -> returns 0x0000_BBAA.
- Split enabled: word store 0x1122_3344 at DM_BASE+6 ->
  - ACC0: dm_addr=DM_BASE+4, dm_be=4'b1100;
  - ACC1: dm_addr=DM_BASE+8, dm_be=4'b0011;
  - reload at DM_BASE+6 returns 0x1122_3344 at T+4.
- Error cases, each returning rsp_err=1, rsp_rdata=0 at T+2 with no dm_wr pulse:
  - store to DM_BASE+DM_BYTES-2 with size=2;
  - size=3;
  - split access with DM_ACC_SPLIT_EN undefined.
- rst_n low for 1 cycle during ACC0 of a split store -> all outputs 0 asynchronously, no ACC1, no rsp_valid; the next request is accepted normally.

Source files
------------

// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl: MEM-stage initiator for the data memory (byte lanes, extension, byte reversal).
// Optional macro DM_ACC_SPLIT_EN: word-crossing half/word accesses become two word accesses.
module dm_access_ctrl #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] DM_BASE  = 32'h0000_3000,
    parameter int                DM_BYTES = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [1:0]        req_size,
    input  logic              req_rev,
    input  logic              req_sext,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [3:0]        dm_be,
    output logic              dm_wr,
    output logic [31:0]       dm_din,
    input  logic [31:0]       dm_dout,
    output logic [2:0]        dbg_state
);

    // Handshake: a request transfers on a rising edge with req_valid && req_ready; req_ready is
    // high only in IDLE, so one request is in flight; rsp_valid is a one-cycle pulse, no backpressure.

    localparam int AW1 = ADDR_W + 1;
`ifdef DM_ACC_SPLIT_EN
    localparam int WIN_B = 8;
`else
    localparam int WIN_B = 4;
`endif
    localparam int WIN_W = 8 * WIN_B;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CHK  = 3'd1,
        S_ACC0 = 3'd2,
`ifdef DM_ACC_SPLIT_EN
        S_ACC1 = 3'd3,
`endif
        S_RESP = 3'd4
    } state_t;

    state_t state, next_state;

    logic              wr_q;
    logic [1:0]        size_q;
    logic              rev_q;
    logic              sext_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       win_lo;
    logic [31:0]       win_hi;

    logic [ADDR_W-1:0] rel;
    logic [1:0]        off;
    logic [2:0]        nbytes;
    logic [3:0]        lane_mask;
    logic [3:0]        span;
    logic              split;
    logic [AW1-1:0]    end_pos;
    logic              range_err;
    logic              err;
    logic [WIN_B-1:0]  mask_w;
    logic [31:0]       wsz;
    logic [WIN_W-1:0]  wwin;
    logic [31:0]       lword;
    logic [31:0]       load_data;
    logic [ADDR_W-1:0] word_addr;

    // Access geometry, derived from the latched request
    assign rel       = addr_q - DM_BASE;
    assign off       = rel[1:0];
    assign span      = {2'b00, off} + {1'b0, nbytes};
    assign split     = span > 4'd4;
    assign end_pos   = {1'b0, rel} + AW1'(nbytes);
    assign range_err = (addr_q < DM_BASE) || (end_pos > AW1'(DM_BYTES));
    assign word_addr = {addr_q[ADDR_W-1:2], 2'b00};
    assign mask_w    = WIN_B'(lane_mask) << off;
    assign wwin      = WIN_W'(wsz) << {off, 3'b000};
    assign dbg_state = state;

`ifdef DM_ACC_SPLIT_EN
    assign err   = (size_q == 2'd3) || range_err;
    assign lword = 32'({win_hi, win_lo} >> {off, 3'b000});
`else
    assign err   = (size_q == 2'd3) || range_err || split;
    assign lword = win_lo >> {off, 3'b000};
`endif

    always_comb begin
        nbytes    = 3'd4;
        lane_mask = 4'b1111;
        case (size_q)
            2'd0: begin
                nbytes    = 3'd1;
                lane_mask = 4'b0001;
            end
            2'd1: begin
                nbytes    = 3'd2;
                lane_mask = 4'b0011;
            end
            default: begin
                nbytes    = 3'd4;
                lane_mask = 4'b1111;
            end
        endcase
    end

    // Store data: reverse within the access size first, then lane placement via wwin
    always_comb begin
        wsz = 32'h0;
        case (size_q)
            2'd0:    wsz = {24'h0, wdata_q[7:0]};
            2'd1:    wsz = rev_q ? {16'h0, wdata_q[7:0], wdata_q[15:8]}
                                 : {16'h0, wdata_q[15:0]};
            default: wsz = rev_q ? {wdata_q[7:0], wdata_q[15:8], wdata_q[23:16], wdata_q[31:24]}
                                 : wdata_q;
        endcase
    end

    // Load data: sign extension only applies to unreversed byte/half loads
    always_comb begin
        load_data = lword;
        case (size_q)
            2'd0: load_data = (sext_q && !rev_q) ? {{24{lword[7]}}, lword[7:0]}
                                                 : {24'h0, lword[7:0]};
            2'd1: begin
                if (rev_q)
                    load_data = {16'h0, lword[7:0], lword[15:8]};
                else if (sext_q)
                    load_data = {{16{lword[15]}}, lword[15:0]};
                else
                    load_data = {16'h0, lword[15:0]};
            end
            default: begin
                if (rev_q)
                    load_data = {lword[7:0], lword[15:8], lword[23:16], lword[31:24]};
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (req_valid) next_state = S_CHK;
            S_CHK:  next_state = err ? S_RESP : S_ACC0;
`ifdef DM_ACC_SPLIT_EN
            S_ACC0: next_state = split ? S_ACC1 : S_RESP;
            S_ACC1: next_state = S_RESP;
`else
            S_ACC0: next_state = S_RESP;
`endif
            S_RESP: next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = rst_n && (state == S_IDLE);
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        rsp_rdata = 32'h0;
        dm_addr   = '0;
        dm_be     = 4'h0;
        dm_wr     = 1'b0;
        dm_din    = 32'h0;
        case (state)
            S_ACC0: begin
                dm_addr = word_addr;
                dm_be   = mask_w[3:0];
                dm_wr   = wr_q;
                dm_din  = wwin[31:0];
            end
`ifdef DM_ACC_SPLIT_EN
            S_ACC1: begin
                dm_addr = word_addr + ADDR_W'(4);
                dm_be   = mask_w[7:4];
                dm_wr   = wr_q;
                dm_din  = wwin[63:32];
            end
`endif
            S_RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = err;
                rsp_rdata = (err || wr_q) ? 32'h0 : load_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= 1'b0;
            size_q  <= 2'd0;
            rev_q   <= 1'b0;
            sext_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            win_lo  <= 32'h0;
        end else begin
            if (state == S_IDLE && req_valid) begin
                wr_q    <= req_wr;
                size_q  <= req_size;
                rev_q   <= req_rev;
                sext_q  <= req_sext;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (state == S_ACC0 && !wr_q)
                win_lo <= dm_dout;
        end
    end

`ifdef DM_ACC_SPLIT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            win_hi <= 32'h0;
        else if (state == S_ACC1 && !wr_q)
            win_hi <= dm_dout;
    end
`else
    assign win_hi = 32'h0;
`endif

endmodule

// File: tb/tb_dm_access_ctrl.sv
// tb_dm_access_ctrl: directed + randomized checks of dm_access_ctrl against a byte-level memory model.
module tb_dm_access_ctrl;
    localparam int          ADDR_W     = 32;
    localparam logic [31:0] DM_BASE    = 32'h0000_3000;
    localparam int          DM_BYTES   = 4096;
    localparam logic [31:0] DM_BYTES_U = 32'd4096;
    localparam int          IDX_W      = $clog2(DM_BYTES);

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wr = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_rev = 1'b0;
    logic        req_sext = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] dm_addr;
    logic [3:0]  dm_be;
    logic        dm_wr;
    logic [31:0] dm_din;
    logic [31:0] dm_dout;
    logic [2:0]  dbg_state;

    // clock / reset
    always #5 clk = ~clk;

    dm_access_ctrl #(.ADDR_W(ADDR_W), .DM_BASE(DM_BASE), .DM_BYTES(DM_BYTES)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr), .req_size(req_size),
        .req_rev(req_rev), .req_sext(req_sext), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .dm_addr(dm_addr), .dm_be(dm_be), .dm_wr(dm_wr), .dm_din(dm_din), .dm_dout(dm_dout),
        .dbg_state(dbg_state)
    );

    // data memory: byte-enabled synchronous write, combinational read
    bit   [31:0] dm_mem [DM_BYTES/4];
    logic [31:0] dm_off;
    assign dm_off = dm_addr - DM_BASE;
    always_comb dm_dout = (dm_off < DM_BYTES_U) ? dm_mem[dm_off[IDX_W-1:2]] : 32'h0;
    always @(posedge clk) begin
        if (dm_wr && dm_off < DM_BYTES_U)
            for (int k = 0; k < 4; k++)
                if (dm_be[k]) dm_mem[dm_off[IDX_W-1:2]][8*k +: 8] <= dm_din[8*k +: 8];
    end

    // scoreboard state
    int n_cmp = 0;
    int n_fail = 0;
    bit [7:0] ref_mem [DM_BYTES];

    bit          e_err;
    logic [31:0] e_rdata, e_addr0, e_addr1;
    int          e_lat, e_nacc, e_nwr;
    logic [3:0]  e_be0, e_be1;

    bit          g_err, g_after_valid, g_after_ready;
    logic [31:0] g_rdata, g_addr0, g_addr1, g_din0;
    int          g_lat, g_nacc, g_nwr;
    logic [3:0]  g_be0, g_be1;

    logic [31:0] rst_a;
    logic [3:0]  rst_be;
    int          bad;
    int          pick;
    logic [31:0] r_addr;
    logic [1:0]  r_size;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] byte_rev(input logic [31:0] v, input int n);
        logic [31:0] r = 32'h0;
        for (int i = 0; i < n; i++) r[8*i +: 8] = v[8*(n-1-i) +: 8];
        return r;
    endfunction

    // reference model: little-endian byte array, rules applied per byte
    task automatic ref_exec(input bit wr, input logic [1:0] size, input bit rev, input bit sext,
                            input logic [31:0] addr, input logic [31:0] wdata);
        int n;
        longint rel;
        bit split;
        logic [31:0] v, b;
        n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        rel = longint'(addr) - longint'(DM_BASE);
        split = (int'(rel & 3) + n) > 4;
        e_err = (size == 2'd3) || (rel < 0) || (rel + n > DM_BYTES);
`ifndef DM_ACC_SPLIT_EN
        if (split) e_err = 1'b1;
`endif
        e_rdata = 32'h0;
        e_be0 = 4'h0;
        e_be1 = 4'h0;
        e_lat = e_err ? 2 : (split ? 4 : 3);
        e_nacc = e_err ? 0 : (split ? 2 : 1);
        e_nwr = wr ? e_nacc : 0;
        e_addr0 = {addr[31:2], 2'b00};
        e_addr1 = e_addr0 + 32'd4;
        if (!e_err) begin
            for (int i = 0; i < n; i++) begin
                b = addr + 32'(i);
                if (b[31:2] == addr[31:2]) e_be0[b[1:0]] = 1'b1;
                else                       e_be1[b[1:0]] = 1'b1;
            end
            if (wr) begin
                v = rev ? byte_rev(wdata, n) : wdata;
                for (int i = 0; i < n; i++) ref_mem[int'(rel) + i] = v[8*i +: 8];
            end else begin
                v = 32'h0;
                for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[int'(rel) + i];
                if (rev) v = byte_rev(v, n);
                else if (sext && n < 4 && v[8*n-1])
                    for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
                e_rdata = v;
            end
        end
    endtask

    // driver: one request, then watch the memory port until the response pulse
    task automatic do_req(input bit wr, input logic [1:0] size, input bit rev, input bit sext,
                          input logic [31:0] addr, input logic [31:0] wdata);
        int w = 0;
        g_lat = 0; g_nacc = 0; g_nwr = 0; g_err = 1'b0; g_rdata = 32'h0;
        g_addr0 = 32'h0; g_addr1 = 32'h0; g_be0 = 4'h0; g_be1 = 4'h0; g_din0 = 32'h0;
        g_after_valid = 1'b1; g_after_ready = 1'b0;
        @(negedge clk);
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!req_ready) begin
            g_lat = -1;
            return;
        end
        req_wr = wr; req_size = size; req_rev = rev; req_sext = sext;
        req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (dm_be != 4'h0) begin
                if (g_nacc == 0) begin
                    g_addr0 = dm_addr; g_be0 = dm_be; g_din0 = dm_din;
                end else if (g_nacc == 1) begin
                    g_addr1 = dm_addr; g_be1 = dm_be;
                end
                g_nacc++;
            end
            if (dm_wr) g_nwr++;
            if (rsp_valid) begin
                g_rdata = rsp_rdata;
                g_err = rsp_err;
                g_lat = k + 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        g_after_valid = rsp_valid;
        g_after_ready = req_ready;
    endtask

    task automatic run(input string tag, input bit wr, input logic [1:0] size, input bit rev,
                       input bit sext, input logic [31:0] addr, input logic [31:0] wdata);
        ref_exec(wr, size, rev, sext, addr, wdata);
        do_req(wr, size, rev, sext, addr, wdata);
        check({tag, "_lat"}, 64'(g_lat), 64'(e_lat));
        check({tag, "_err"}, 64'(g_err), 64'(e_err));
        check({tag, "_rdata"}, 64'(g_rdata), 64'(e_rdata));
        check({tag, "_nacc"}, 64'(g_nacc), 64'(e_nacc));
        check({tag, "_nwr"}, 64'(g_nwr), 64'(e_nwr));
        check({tag, "_pulse"}, 64'(g_after_valid), 64'd0);
        check({tag, "_idle"}, 64'(g_after_ready), 64'd1);
        if (e_nacc > 0) begin
            check({tag, "_addr0"}, 64'(g_addr0), 64'(e_addr0));
            check({tag, "_be0"}, 64'(g_be0), 64'(e_be0));
        end
        if (e_nacc > 1) begin
            check({tag, "_addr1"}, 64'(g_addr1), 64'(e_addr1));
            check({tag, "_be1"}, 64'(g_be1), 64'(e_be1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // reset values
        #2;
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_err", 64'(rsp_err), 64'd0);
        check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        check("rst_dm_be", 64'(dm_be), 64'd0);
        check("rst_dm_wr", 64'(dm_wr), 64'd0);
        check("rst_dm_addr", 64'(dm_addr), 64'd0);
        check("rst_dm_din", 64'(dm_din), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("idle_ready", 64'(req_ready), 64'd1);

        // aligned word store / load
        run("st_word", 1'b1, 2'd2, 1'b0, 1'b0, DM_BASE + 32'h8, 32'h1234_5678);
        check("st_word_be_f", 64'(g_be0), 64'hF);
        check("st_word_one_wr", 64'(g_nwr), 64'd1);
        run("ld_word", 1'b0, 2'd2, 1'b0, 1'b0, DM_BASE + 32'h8, 32'h0);
        check("ld_word_value", 64'(g_rdata), 64'h1234_5678);
        check("ld_word_t3", 64'(g_lat), 64'd3);

        // byte store and signed/unsigned byte loads
        run("st_byte", 1'b1, 2'd0, 1'b0, 1'b0, DM_BASE + 32'hD, 32'h0000_00A5);
        check("st_byte_be", 64'(g_be0), 64'b0010);
        check("st_byte_lane", 64'(g_din0[15:8]), 64'hA5);
        run("ld_sbyte", 1'b0, 2'd0, 1'b0, 1'b1, DM_BASE + 32'hD, 32'h0);
        check("ld_sbyte_value", 64'(g_rdata), 64'hFFFF_FFA5);
        run("ld_ubyte", 1'b0, 2'd0, 1'b0, 1'b0, DM_BASE + 32'hD, 32'h0);
        check("ld_ubyte_value", 64'(g_rdata), 64'h0000_00A5);
        run("ld_byte_rev_sext", 1'b0, 2'd0, 1'b1, 1'b1, DM_BASE + 32'hD, 32'h0);

        // reversed halfword, half at offset 1, reversed word store
        run("st_w2", 1'b1, 2'd2, 1'b0, 1'b0, DM_BASE + 32'h10, 32'hAABB_CCDD);
        run("ld_hrev", 1'b0, 2'd1, 1'b1, 1'b0, DM_BASE + 32'h12, 32'h0);
        check("ld_hrev_value", 64'(g_rdata), 64'h0000_BBAA);
        run("ld_h_off1", 1'b0, 2'd1, 1'b0, 1'b1, DM_BASE + 32'h11, 32'h0);
        check("ld_h_off1_value", 64'(g_rdata), 64'hFFFF_BBCC);
        run("st_wrev", 1'b1, 2'd2, 1'b1, 1'b0, DM_BASE + 32'h18, 32'h1122_3344);
        run("ld_wrev", 1'b0, 2'd2, 1'b0, 1'b0, DM_BASE + 32'h18, 32'h0);
        check("ld_wrev_value", 64'(g_rdata), 64'h4433_2211);
        run("st_hrev", 1'b1, 2'd1, 1'b1, 1'b0, DM_BASE + 32'h1C, 32'h0000_BEEF);
        run("ld_h_after_rev", 1'b0, 2'd1, 1'b0, 1'b0, DM_BASE + 32'h1C, 32'h0);
        check("ld_h_after_rev_value", 64'(g_rdata), 64'h0000_EFBE);

        // word-crossing access
        run("st_split", 1'b1, 2'd2, 1'b0, 1'b0, DM_BASE + 32'h6, 32'h1122_3344);
`ifdef DM_ACC_SPLIT_EN
        check("st_split_addr0", 64'(g_addr0), 64'(DM_BASE + 32'h4));
        check("st_split_be0", 64'(g_be0), 64'b1100);
        check("st_split_addr1", 64'(g_addr1), 64'(DM_BASE + 32'h8));
        check("st_split_be1", 64'(g_be1), 64'b0011);
        run("ld_split", 1'b0, 2'd2, 1'b0, 1'b0, DM_BASE + 32'h6, 32'h0);
        check("ld_split_value", 64'(g_rdata), 64'h1122_3344);
        check("ld_split_t4", 64'(g_lat), 64'd4);
`else
        check("st_split_err", 64'(g_err), 64'd1);
        check("st_split_no_wr", 64'(g_nwr), 64'd0);
        check("st_split_t2", 64'(g_lat), 64'd2);
        run("ld_split", 1'b0, 2'd2, 1'b0, 1'b0, DM_BASE + 32'h6, 32'h0);
`endif
        run("ld_h_off3", 1'b0, 2'd1, 1'b0, 1'b1, DM_BASE + 32'h13, 32'h0);

        // errors and range boundaries
        run("err_top", 1'b1, 2'd2, 1'b0, 1'b0, DM_BASE + DM_BYTES_U - 32'd2, 32'hCAFE_F00D);
        check("err_top_flag", 64'(g_err), 64'd1);
        check("err_top_rdata", 64'(g_rdata), 64'd0);
        check("err_top_t2", 64'(g_lat), 64'd2);
        check("err_top_no_wr", 64'(g_nwr), 64'd0);
        run("err_size3", 1'b1, 2'd3, 1'b0, 1'b0, DM_BASE + 32'h20, 32'hFFFF_FFFF);
        check("err_size3_flag", 64'(g_err), 64'd1);
        check("err_size3_no_wr", 64'(g_nwr), 64'd0);
        run("err_below", 1'b0, 2'd2, 1'b0, 1'b0, DM_BASE - 32'd4, 32'h0);
        run("ok_top_word", 1'b1, 2'd2, 1'b0, 1'b0, DM_BASE + DM_BYTES_U - 32'd4, 32'h5A5A_0FF0);
        run("ld_top_word", 1'b0, 2'd2, 1'b0, 1'b0, DM_BASE + DM_BYTES_U - 32'd4, 32'h0);
        run("err_past_top", 1'b0, 2'd0, 1'b0, 1'b0, DM_BASE + DM_BYTES_U, 32'h0);

        // reset during the first word access of a store
`ifdef DM_ACC_SPLIT_EN
        rst_a = DM_BASE + 32'h26;
        rst_be = 4'b1100;
`else
        rst_a = DM_BASE + 32'h28;
        rst_be = 4'b1111;
`endif
        @(negedge clk);
        for (int w = 0; w < 20 && !req_ready; w++) @(negedge clk);
        req_wr = 1'b1; req_size = 2'd2; req_rev = 1'b0; req_sext = 1'b0;
        req_addr = rst_a; req_wdata = 32'hDEAD_BEEF; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("mid_acc0_be", 64'(dm_be), 64'(rst_be));
        check("mid_acc0_wr", 64'(dm_wr), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", 64'(req_ready), 64'd0);
        check("mid_rst_be", 64'(dm_be), 64'd0);
        check("mid_rst_wr", 64'(dm_wr), 64'd0);
        check("mid_rst_addr", 64'(dm_addr), 64'd0);
        check("mid_rst_din", 64'(dm_din), 64'd0);
        check("mid_rst_valid", 64'(rsp_valid), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        bad = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (rsp_valid || dm_be != 4'h0 || dm_wr) bad++;
        end
        check("mid_rst_quiet", 64'(bad), 64'd0);
        check("mid_rst_ready_again", 64'(req_ready), 64'd1);
        run("ld_after_rst", 1'b0, 2'd2, 1'b0, 1'b0, DM_BASE + 32'h8, 32'h0);

        // randomized traffic
        for (int i = 0; i < 80; i++) begin
            pick = $urandom_range(0, 9);
            if (pick == 0)
                r_addr = DM_BASE + DM_BYTES_U - 32'd8 + 32'($urandom_range(0, 9));
            else if (pick == 1)
                r_addr = DM_BASE - 32'($urandom_range(1, 8));
            else
                r_addr = DM_BASE + 32'h100 + 32'($urandom_range(0, 63));
            r_size = ($urandom_range(0, 11) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            run($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), r_size,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), r_addr, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
